// File: rtl/mcountp.sv
// Loadable down-counter with one-shot or auto-reload terminal count, done pulse and reload tally.
// Latency: count/busy/done/rlcnt update one clk after the inputs are sampled; count0/count1 are direct decodes.
// Backpressure: none; cnten is a qualify-only enable and cntld always wins over it.
module mcountp #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetl,
   input  logic             cntld,
   input  logic             cnten,
   input  logic             autorl,
   input  logic [WIDTH-1:0] mwidth,
   output logic [WIDTH-1:0] count,
   output logic             count1,
   output logic             count0,
   output logic             busy,
   output logic             done,
   output logic [7:0]       rlcnt
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [7:0]       RL_MAX   = 8'hFF;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] rld_q,   rld_d;
   logic             done_q,  done_d;
   logic [7:0]       rlcnt_q, rlcnt_d;

   logic             at_one;
   logic             at_zero;

   assign at_one  = (count_q == CNT_ONE);
   assign at_zero = (count_q == CNT_ZERO);

   // Next-state decision: load beats everything, then terminal count, then plain decrement.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rld_d   = rld_q;
      rlcnt_d = rlcnt_q;
      done_d  = 1'b0;
      if (cntld) begin
         count_d = mwidth;
         rld_d   = mwidth;
         rlcnt_d = 8'd0;
         state_d = (mwidth != CNT_ZERO) ? RUN : IDLE;
      end else if (cnten && (state_q == RUN)) begin
         if (at_one) begin
            // autorl only matters here, so a mid-run change affects the next terminal count only
            done_d = 1'b1;
            if (autorl) begin
               count_d = rld_q;
               if (rlcnt_q != RL_MAX) begin
                  rlcnt_d = rlcnt_q + 8'd1;
               end
            end else begin
               count_d = CNT_ZERO;
               state_d = IDLE;
            end
         end else if (!at_zero) begin
            // RUN never holds zero; the guard keeps the counter from wrapping regardless
            count_d = count_q - CNT_ONE;
         end
      end
   end

   // Counter state, reload value, FSM and registered done pulse.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state_q <= IDLE;
         count_q <= CNT_ZERO;
         rld_q   <= CNT_ZERO;
         done_q  <= 1'b0;
         rlcnt_q <= 8'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rld_q   <= rld_d;
         done_q  <= done_d;
         rlcnt_q <= rlcnt_d;
      end
   end

   assign count  = count_q;
   assign count1 = at_one;
   assign count0 = at_zero;
   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign rlcnt  = rlcnt_q;

endmodule

// File: tb/tb_mcountp.sv
// Self-checking bench for mcountp at WIDTH=4: vector table plus hand-built multi-cycle sequences.
// Latency: each vector is driven after an edge and its expected state is checked 1 time unit after the next edge.
// Backpressure: not applicable; expectations queue up as stimulus is driven and drain as the DUT updates.
module tb_mcountp;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         resetl;
   logic         cntld;
   logic         cnten;
   logic         autorl;
   logic [W-1:0] mwidth;
   logic [W-1:0] count;
   logic         count1;
   logic         count0;
   logic         busy;
   logic         done;
   logic [7:0]   rlcnt;

   mcountp #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetl (resetl),
      .cntld  (cntld),
      .cnten  (cnten),
      .autorl (autorl),
      .mwidth (mwidth),
      .count  (count),
      .count1 (count1),
      .count0 (count0),
      .busy   (busy),
      .done   (done),
      .rlcnt  (rlcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         ld;
      logic         en;
      logic         ar;
      logic [W-1:0] mw;
      logic [W-1:0] cnt;
      logic         bsy;
      logic         dn;
      logic [7:0]   rl;
      string        name;
   } vec_t;

   typedef struct {
      logic [W-1:0] cnt;
      logic         c1;
      logic         c0;
      logic         bsy;
      logic         dn;
      logic [7:0]   rl;
      string        name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic vec_t mk(input string nm, input logic ld, input logic en, input logic ar,
                               input logic [W-1:0] mw, input logic [W-1:0] cnt,
                               input logic bsy, input logic dn, input logic [7:0] rl);
      vec_t v;
      v.name = nm; v.ld = ld; v.en = en; v.ar = ar; v.mw = mw;
      v.cnt = cnt; v.bsy = bsy; v.dn = dn; v.rl = rl;
      return v;
   endfunction

   // Expected flags follow straight from the expected count value.
   task automatic push_exp(input string nm, input logic [W-1:0] cnt, input logic bsy,
                           input logic dn, input logic [7:0] rl);
      exp_t e;
      e.name = nm; e.cnt = cnt; e.bsy = bsy; e.dn = dn; e.rl = rl;
      e.c1 = (cnt == 4'd1);
      e.c0 = (cnt == 4'd0);
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard_empty: got no pending expectation, required one");
         return;
      end
      e = sb.pop_front();
      n_total++;
      if (count === e.cnt && count1 === e.c1 && count0 === e.c0 && busy === e.bsy &&
          done === e.dn && rlcnt === e.rl) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got cnt=%0d c1=%b c0=%b busy=%b done=%b rl=%0d, required cnt=%0d c1=%b c0=%b busy=%b done=%b rl=%0d",
                  e.name, count, count1, count0, busy, done, rlcnt,
                  e.cnt, e.c1, e.c0, e.bsy, e.dn, e.rl);
      end
   endtask

   task automatic step(input string nm, input logic ld, input logic en, input logic ar,
                       input logic [W-1:0] mw, input logic [W-1:0] cnt,
                       input logic bsy, input logic dn, input logic [7:0] rl);
      cntld  = ld;
      cnten  = en;
      autorl = ar;
      mwidth = mw;
      push_exp(nm, cnt, bsy, dn, rl);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // one-shot load 3, count down, then idle with cnten still high
      tbl.push_back(mk("os_load3",   1, 0, 0, 3, 3, 1, 0, 0));
      tbl.push_back(mk("os_dec2",    0, 1, 0, 0, 2, 1, 0, 0));
      tbl.push_back(mk("os_dec1",    0, 1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk("os_tc",      0, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk("os_idle_a",  0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("os_idle_b",  0, 1, 0, 0, 0, 0, 0, 0));
      // auto-reload with load 2: 1,2,1,2,... and four reloads in eight enables
      tbl.push_back(mk("ar_load2",   1, 0, 1, 2, 2, 1, 0, 0));
      tbl.push_back(mk("ar_e1",      0, 1, 1, 0, 1, 1, 0, 0));
      tbl.push_back(mk("ar_e2",      0, 1, 1, 0, 2, 1, 1, 1));
      tbl.push_back(mk("ar_e3",      0, 1, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk("ar_e4",      0, 1, 1, 0, 2, 1, 1, 2));
      tbl.push_back(mk("ar_e5",      0, 1, 1, 0, 1, 1, 0, 2));
      tbl.push_back(mk("ar_e6",      0, 1, 1, 0, 2, 1, 1, 3));
      tbl.push_back(mk("ar_e7",      0, 1, 1, 0, 1, 1, 0, 3));
      tbl.push_back(mk("ar_e8",      0, 1, 1, 0, 2, 1, 1, 4));
      tbl.push_back(mk("ar_hold",    0, 0, 1, 9, 2, 1, 0, 4));
      tbl.push_back(mk("ar_to1",     0, 1, 1, 0, 1, 1, 0, 4));
      // load wins over enable while count is 1
      tbl.push_back(mk("ld_pri",     1, 1, 1, 5, 5, 1, 0, 0));
      // autorl only matters at the terminal edge
      tbl.push_back(mk("mid_4",      0, 1, 0, 0, 4, 1, 0, 0));
      tbl.push_back(mk("mid_3",      0, 1, 0, 0, 3, 1, 0, 0));
      tbl.push_back(mk("mid_2",      0, 1, 0, 0, 2, 1, 0, 0));
      tbl.push_back(mk("mid_1",      0, 1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk("mid_tc_ar",  0, 1, 1, 0, 5, 1, 1, 1));
      tbl.push_back(mk("mid_4b",     0, 1, 0, 0, 4, 1, 0, 1));
      tbl.push_back(mk("mid_3b",     0, 1, 1, 0, 3, 1, 0, 1));
      tbl.push_back(mk("mid_2b",     0, 1, 1, 0, 2, 1, 0, 1));
      tbl.push_back(mk("mid_1b",     0, 1, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk("mid_tc_os",  0, 1, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk("mid_idle",   0, 1, 1, 0, 0, 0, 0, 1));
      // zero load stays idle and never fires
      tbl.push_back(mk("z_load",     1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("z_en_a",     0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("z_en_b",     0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk("z_hold",     0, 0, 1, 0, 0, 0, 0, 0));
      // load 1: count1 right away, terminal count on first enable
      tbl.push_back(mk("one_load",   1, 0, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk("one_hold",   0, 0, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk("one_tc",     0, 1, 0, 0, 0, 0, 1, 0));

      resetl = 1'b0;
      cntld  = 1'b0;
      cnten  = 1'b0;
      autorl = 1'b0;
      mwidth = '0;

      @(posedge clk);
      #1;
      push_exp("reset_state", 0, 0, 0, 0);
      pop_check();
      resetl = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].name, tbl[i].ld, tbl[i].en, tbl[i].ar, tbl[i].mw,
              tbl[i].cnt, tbl[i].bsy, tbl[i].dn, tbl[i].rl);
      end

      // full-scale reload: one done every 15 enabled cycles
      step("max_load", 1, 0, 1, 4'hF, 4'hF, 1, 0, 0);
      for (int p = 0; p < 2; p++) begin
         for (int k = 1; k <= 15; k++) begin
            step("max_period", 0, 1, 1, 0,
                 (k == 15) ? 4'(15) : 4'(15 - k), 1, (k == 15), 8'(p + ((k == 15) ? 1 : 0)));
         end
      end

      // reload value 1: done stays high, rlcnt saturates
      step("sat_load", 1, 0, 1, 1, 1, 1, 0, 0);
      for (int k = 1; k <= 300; k++) begin
         step("sat_run", 0, 1, 1, 0, 1, 1, 1, (k > 255) ? 8'd255 : 8'(k));
      end

      // asynchronous reset mid-run, then no done after release
      step("rst_load3", 1, 0, 0, 3, 3, 1, 0, 0);
      step("rst_dec2",  0, 1, 0, 0, 2, 1, 0, 0);
      #2;
      resetl = 1'b0;
      #1;
      push_exp("rst_async", 0, 0, 0, 0);
      pop_check();
      cntld  = 1'b1;
      cnten  = 1'b1;
      mwidth = 4'd7;
      @(posedge clk);
      #1;
      push_exp("rst_ignores_ld", 0, 0, 0, 0);
      pop_check();
      resetl = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step("rst_after", 0, 1, 0, 0, 0, 0, 0, 0);
      end
      step("rst_reload", 1, 0, 0, 2, 2, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
